rv64_trap_ctrl: RTL and testbench

Trap sequencer that sits directly upstream of `rv64_csr_regfile` and drives its dedicated mstatus/mepc/mcause/mtval write ports. It takes synchronous exceptions and `mret` from the commit stage, plus the machine timer interrupt, and runs a short state machine that saves or restores trap state. It then issues a one-cycle PC redirect to the fetch stage and stalls the pipeline while the sequence is in flight.

---
 rtl/rv64_trap_ctrl_if.sv | 53 +++++
 rtl/rv64_trap_ctrl.sv | 138 +++++++++++++
 tb/tb_rv64_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv64_trap_ctrl_if.sv
// Bundle between the commit stage / CSR regfile and the trap sequencer.
// master = pipeline and regfile side, slave = rv64_trap_ctrl.
interface rv64_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            trap_valid_i;
    logic [XLEN-1:0] trap_cause_i;
    logic [XLEN-1:0] trap_pc_i;
    logic [XLEN-1:0] trap_tval_i;
    logic            mret_valid_i;
    logic [XLEN-1:0] commit_pc_i;
    logic            commit_valid_i;
    logic            irq_timer_i;
    logic            mie_mtie_i;
    logic [XLEN-1:0] csr_mstatus_readdata_i;
    logic [XLEN-1:0] csr_mepc_readdata_i;
    logic [XLEN-1:0] csr_mtvec_readdata_i;

    logic [XLEN-1:0] csr_mstatus_writedata_o;
    logic [XLEN-1:0] csr_mepc_writedata_o;
    logic [XLEN-1:0] csr_mcause_writedata_o;
    logic [XLEN-1:0] csr_mtval_writedata_o;
    logic            csr_mstatus_write_valid_o;
    logic            csr_mepc_write_valid_o;
    logic            csr_mcause_write_valid_o;
    logic            csr_mtval_write_valid_o;
    logic            busy_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [1:0]      state_dbg;

    // Requests are single-cycle offers with no ready: they are taken only when
    // the sequencer is idle (busy_o low before the request); otherwise dropped.
    modport master (
        output trap_valid_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_valid_i,
               commit_pc_i, commit_valid_i, irq_timer_i, mie_mtie_i,
               csr_mstatus_readdata_i, csr_mepc_readdata_i, csr_mtvec_readdata_i,
        input  csr_mstatus_writedata_o, csr_mepc_writedata_o, csr_mcause_writedata_o,
               csr_mtval_writedata_o, csr_mstatus_write_valid_o, csr_mepc_write_valid_o,
               csr_mcause_write_valid_o, csr_mtval_write_valid_o, busy_o,
               redirect_valid_o, redirect_pc_o, state_dbg
    );

    modport slave (
        input  trap_valid_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_valid_i,
               commit_pc_i, commit_valid_i, irq_timer_i, mie_mtie_i,
               csr_mstatus_readdata_i, csr_mepc_readdata_i, csr_mtvec_readdata_i,
        output csr_mstatus_writedata_o, csr_mepc_writedata_o, csr_mcause_writedata_o,
               csr_mtval_writedata_o, csr_mstatus_write_valid_o, csr_mepc_write_valid_o,
               csr_mcause_write_valid_o, csr_mtval_write_valid_o, busy_o,
               redirect_valid_o, redirect_pc_o, state_dbg
    );
endinterface

// File: rtl/rv64_trap_ctrl.sv
// Machine-mode trap sequencer: saves/restores trap CSRs, then issues a
// one-cycle fetch redirect while stalling the pipeline.
module rv64_trap_ctrl #(
    parameter int          XLEN        = 64,
    parameter int unsigned TIMER_CAUSE = 7
) (
    input logic              clk,
    input logic              rst,
    rv64_trap_ctrl_if.slave  bus
);
    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(TIMER_CAUSE)};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        JUMP    = 2'd3
    } state_t;

    state_t          state;
    logic            is_irq;
    // Only the low cause bits survive the x4 vector offset modulo 2^XLEN.
    logic [XLEN-3:0] vec_idx;

    logic            irq_req;
    logic            accept;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] save_mstatus;
    logic [XLEN-1:0] restore_mstatus;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    always_comb begin
        mstatus_rd = bus.csr_mstatus_readdata_i;
        irq_req    = bus.irq_timer_i & bus.mie_mtie_i & mstatus_rd[3] & bus.commit_valid_i;
        accept     = (state == IDLE) & ~rst & (bus.trap_valid_i | bus.mret_valid_i | irq_req);
        bus.busy_o = (state != IDLE) | accept;

        save_mstatus        = mstatus_rd;
        save_mstatus[7]     = mstatus_rd[3];
        save_mstatus[3]     = 1'b0;
        save_mstatus[12:11] = 2'b11;

        restore_mstatus        = mstatus_rd;
        restore_mstatus[3]     = mstatus_rd[7];
        restore_mstatus[7]     = 1'b1;
        restore_mstatus[12:11] = 2'b11;

        trap_base   = {bus.csr_mtvec_readdata_i[XLEN-1:2], 2'b00};
        trap_target = trap_base;
        // Only mode 1 vectors, and only for interrupts; modes 2/3 act as direct.
        if (is_irq && (bus.csr_mtvec_readdata_i[1:0] == 2'b01)) begin
            trap_target = trap_base + {vec_idx, 2'b00};
        end
    end

    assign bus.state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                         <= IDLE;
            is_irq                        <= 1'b0;
            vec_idx                       <= '0;
            bus.csr_mstatus_writedata_o   <= '0;
            bus.csr_mepc_writedata_o      <= '0;
            bus.csr_mcause_writedata_o    <= '0;
            bus.csr_mtval_writedata_o     <= '0;
            bus.csr_mstatus_write_valid_o <= 1'b0;
            bus.csr_mepc_write_valid_o    <= 1'b0;
            bus.csr_mcause_write_valid_o  <= 1'b0;
            bus.csr_mtval_write_valid_o   <= 1'b0;
            bus.redirect_valid_o          <= 1'b0;
            bus.redirect_pc_o             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.trap_valid_i) begin
                        state                         <= SAVE;
                        is_irq                        <= 1'b0;
                        vec_idx                       <= bus.trap_cause_i[XLEN-3:0];
                        bus.csr_mstatus_write_valid_o <= 1'b1;
                        bus.csr_mepc_write_valid_o    <= 1'b1;
                        bus.csr_mcause_write_valid_o  <= 1'b1;
                        bus.csr_mtval_write_valid_o   <= 1'b1;
                        bus.csr_mstatus_writedata_o   <= save_mstatus;
                        bus.csr_mepc_writedata_o      <= {bus.trap_pc_i[XLEN-1:2], 2'b00};
                        bus.csr_mcause_writedata_o    <= bus.trap_cause_i;
                        bus.csr_mtval_writedata_o     <= bus.trap_tval_i;
                    end else if (bus.mret_valid_i) begin
                        state                         <= RESTORE;
                        is_irq                        <= 1'b0;
                        bus.csr_mstatus_write_valid_o <= 1'b1;
                        bus.csr_mstatus_writedata_o   <= restore_mstatus;
                    end else if (irq_req) begin
                        state                         <= SAVE;
                        is_irq                        <= 1'b1;
                        vec_idx                       <= IRQ_CAUSE[XLEN-3:0];
                        bus.csr_mstatus_write_valid_o <= 1'b1;
                        bus.csr_mepc_write_valid_o    <= 1'b1;
                        bus.csr_mcause_write_valid_o  <= 1'b1;
                        bus.csr_mtval_write_valid_o   <= 1'b1;
                        bus.csr_mstatus_writedata_o   <= save_mstatus;
                        bus.csr_mepc_writedata_o      <= {bus.commit_pc_i[XLEN-1:2], 2'b00};
                        bus.csr_mcause_writedata_o    <= IRQ_CAUSE;
                        bus.csr_mtval_writedata_o     <= '0;
                    end
                end
                SAVE: begin
                    state                         <= JUMP;
                    bus.csr_mstatus_write_valid_o <= 1'b0;
                    bus.csr_mepc_write_valid_o    <= 1'b0;
                    bus.csr_mcause_write_valid_o  <= 1'b0;
                    bus.csr_mtval_write_valid_o   <= 1'b0;
                    bus.csr_mstatus_writedata_o   <= '0;
                    bus.csr_mepc_writedata_o      <= '0;
                    bus.csr_mcause_writedata_o    <= '0;
                    bus.csr_mtval_writedata_o     <= '0;
                    bus.redirect_valid_o          <= 1'b1;
                    bus.redirect_pc_o             <= trap_target;
                end
                RESTORE: begin
                    // mepc is never written by the sequence, so this read is the return PC.
                    state                         <= JUMP;
                    bus.csr_mstatus_write_valid_o <= 1'b0;
                    bus.csr_mstatus_writedata_o   <= '0;
                    bus.redirect_valid_o          <= 1'b1;
                    bus.redirect_pc_o             <= bus.csr_mepc_readdata_i;
                end
                JUMP: begin
                    state                <= IDLE;
                    bus.redirect_valid_o <= 1'b0;
                    bus.redirect_pc_o    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Self-checking bench for rv64_trap_ctrl: directed and random requests, a
// CSR model and a scoreboard of expected CSR writes and redirects.
module tb_rv64_trap_ctrl;
    localparam int XLEN = 64;
    localparam int WR_W = 4 + 4 * XLEN;
    localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv64_trap_ctrl_if #(.XLEN(XLEN)) bus ();

    rv64_trap_ctrl #(.XLEN(XLEN), .TIMER_CAUSE(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Regfile model seen by the sequencer
    logic [63:0] csr_mstatus = '0;
    logic [63:0] csr_mepc    = '0;
    logic [63:0] csr_mtvec   = '0;
    assign bus.csr_mstatus_readdata_i = csr_mstatus;
    assign bus.csr_mepc_readdata_i    = csr_mepc;
    assign bus.csr_mtvec_readdata_i   = csr_mtvec;

    logic [WR_W-1:0] exp_wr_q[$];
    logic [XLEN-1:0] exp_rd_q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_wr_cyc = -10;
    logic [WR_W-1:0] mon_wr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WR_W-1:0] act, input logic [WR_W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_save_ms(input logic [63:0] ms);
        logic [63:0] r;
        r = (ms & ~64'h1888) | 64'h1800;
        if (ms[3]) r = r | 64'h80;
        return r;
    endfunction

    function automatic logic [63:0] model_restore_ms(input logic [63:0] ms);
        logic [63:0] r;
        r = (ms & ~64'h1888) | 64'h1880;
        if (ms[7]) r = r | 64'h8;
        return r;
    endfunction

    function automatic logic [63:0] model_target(input logic [63:0] mtvec, input logic [63:0] cause,
                                                 input bit irq);
        logic [63:0] base;
        base = mtvec & ~64'h3;
        if (irq && (mtvec % 4 == 1)) return base + cause * 64'd4;
        return base;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        mon_wr = {bus.csr_mstatus_write_valid_o, bus.csr_mepc_write_valid_o,
                  bus.csr_mcause_write_valid_o, bus.csr_mtval_write_valid_o,
                  bus.csr_mstatus_writedata_o, bus.csr_mepc_writedata_o,
                  bus.csr_mcause_writedata_o, bus.csr_mtval_writedata_o};
        if (|mon_wr[WR_W-1 -: 4]) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_csr_write: got %0h required none", mon_wr);
            end else begin
                check("csr_write", mon_wr, exp_wr_q.pop_front());
            end
            last_wr_cyc = cyc;
        end
        if (bus.redirect_valid_o) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_redirect: got %0h required none", bus.redirect_pc_o);
            end else begin
                check("redirect_pc", bus.redirect_pc_o, exp_rd_q.pop_front());
                check("redirect_timing", cyc, last_wr_cyc + 1);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        bus.trap_valid_i   = 1'b0;
        bus.trap_cause_i   = '0;
        bus.trap_pc_i      = '0;
        bus.trap_tval_i    = '0;
        bus.mret_valid_i   = 1'b0;
        bus.commit_pc_i    = '0;
        bus.commit_valid_i = 1'b0;
        bus.irq_timer_i    = 1'b0;
        bus.mie_mtie_i     = 1'b0;
    endtask

    // One request slot; the model decides what the sequencer should do.
    task automatic issue(input bit t, input bit m, input bit irq, input bit mtie, input bit cv,
                         input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                         input logic [63:0] cpc, input bit hold_trap);
        int kind;
        logic [63:0] nms;
        logic [63:0] nepc;
        @(negedge clk);
        if (t) kind = 1;
        else if (m) kind = 2;
        else if (irq && mtie && csr_mstatus[3] && cv) kind = 3;
        else kind = 0;
        bus.trap_valid_i   = t;
        bus.trap_cause_i   = cause;
        bus.trap_pc_i      = pc;
        bus.trap_tval_i    = tval;
        bus.mret_valid_i   = m;
        bus.irq_timer_i    = irq;
        bus.mie_mtie_i     = mtie;
        bus.commit_valid_i = cv;
        bus.commit_pc_i    = cpc;
        nms  = csr_mstatus;
        nepc = csr_mepc;
        case (kind)
            1: begin
                nms  = model_save_ms(csr_mstatus);
                nepc = pc & ~64'h3;
                exp_wr_q.push_back({4'hF, nms, nepc, cause, tval});
                exp_rd_q.push_back(model_target(csr_mtvec, cause, 1'b0));
            end
            2: begin
                nms = model_restore_ms(csr_mstatus);
                exp_wr_q.push_back({4'h8, nms, 192'd0});
                exp_rd_q.push_back(csr_mepc);
            end
            3: begin
                nms  = model_save_ms(csr_mstatus);
                nepc = cpc & ~64'h3;
                exp_wr_q.push_back({4'hF, nms, nepc, IRQ_CAUSE, 64'd0});
                exp_rd_q.push_back(model_target(csr_mtvec, IRQ_CAUSE, 1'b1));
            end
            default: ;
        endcase
        #1 check("busy_accept", bus.busy_o, (kind != 0));
        @(negedge clk);
        clear_inputs();
        if (kind != 0) begin
            if (hold_trap) begin
                bus.trap_valid_i = 1'b1;
                bus.trap_cause_i = 64'd99;
                bus.trap_pc_i    = 64'h1234;
            end
            #1 check("busy_seq1", bus.busy_o, 1);
            csr_mstatus = nms;
            csr_mepc    = nepc;
            @(negedge clk);
            clear_inputs();
            #1 check("busy_seq2", bus.busy_o, 1);
            @(negedge clk);
            #1 check("busy_done", bus.busy_o, 0);
        end
    endtask

    task automatic quiet(input bit mtie, input bit cv, input int n);
        @(negedge clk);
        bus.irq_timer_i    = 1'b1;
        bus.mie_mtie_i     = mtie;
        bus.commit_valid_i = cv;
        bus.commit_pc_i    = 64'h8000_0300;
        for (int i = 0; i < n; i++) begin
            #1 check("masked_busy", bus.busy_o, 0);
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy_o, 0);
        check("rst_redirect", {bus.redirect_valid_o, bus.redirect_pc_o}, 0);
        check("rst_valids", {bus.csr_mstatus_write_valid_o, bus.csr_mepc_write_valid_o,
                             bus.csr_mcause_write_valid_o, bus.csr_mtval_write_valid_o}, 0);
        check("rst_state", bus.state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // exception save and jump
        csr_mtvec   = 64'h8000_0100;
        csr_mstatus = 64'h8;
        issue(1, 0, 0, 0, 0, 64'd11, 64'h8000_0040, 64'd0, 64'd0, 0);
        check("t1_mstatus_model", csr_mstatus, 64'h1880);

        // mret
        csr_mepc = 64'h8000_0044;
        issue(0, 1, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0);

        // vectored timer interrupt (MIE restored to 1 by the mret)
        csr_mtvec = 64'h8000_0101;
        issue(0, 0, 1, 1, 1, 64'd0, 64'd0, 64'd0, 64'h8000_0200, 0);

        // masking
        csr_mstatus = 64'h0;
        quiet(1, 1, 10);
        csr_mstatus = 64'h8;
        quiet(1, 0, 10);

        // priority: trap beats irq, trap beats mret, trap ignored mid-sequence
        issue(1, 0, 1, 1, 1, 64'd5, 64'h8000_0080, 64'hdead, 64'h8000_0400, 0);
        csr_mstatus = 64'h8;
        issue(1, 1, 0, 0, 0, 64'd2, 64'h8000_0090, 64'h0bad, 64'd0, 1);

        // random mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) csr_mtvec = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) csr_mstatus = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) csr_mepc = {$urandom, $urandom};
            issue($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end

        // reset during SAVE: no redirect may follow
        @(negedge clk);
        bus.trap_valid_i = 1'b1;
        bus.trap_cause_i = 64'd3;
        bus.trap_pc_i    = 64'h8000_0500;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_valids", {bus.csr_mstatus_write_valid_o, bus.csr_mepc_write_valid_o,
                                    bus.csr_mcause_write_valid_o, bus.csr_mtval_write_valid_o}, 0);
        check("rst_mid_busy", bus.busy_o, 0);
        check("rst_mid_state", bus.state_dbg, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("rst_mid_no_redirect", bus.redirect_valid_o, 0);

        repeat (2) @(negedge clk);
        check("exp_wr_drained", exp_wr_q.size(), 0);
        check("exp_rd_drained", exp_rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
